vga_sync_controller: RTL

//  Timing generator for the 640x480@60Hz VGA output on the Basys 3.

---
 rtl/vga_sync_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_sync_controller.sv
// 640x480@60Hz VGA timing generator: pixel-rate divider, raw scan counters,
// registered sync/video_on aligned with x/y, and pixel/frame tick decodes.
module vga_sync_controller #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_video_on,
    output logic       o_p_tick,
    output logic       o_frame_tick,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

    localparam logic [1:0] DIV_LAST    = 2'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_HS_FIRST  = 10'(HS_FIRST);
    localparam logic [9:0] X_HS_LAST   = 10'(HS_LAST);
    localparam logic [9:0] Y_VS_FIRST  = 10'(VS_FIRST);
    localparam logic [9:0] Y_VS_LAST   = 10'(VS_LAST);
    localparam logic [9:0] X_VIS_LAST  = 10'(H_DISPLAY - 1);
    localparam logic [9:0] Y_VIS_LAST  = 10'(V_DISPLAY - 1);

    logic [1:0] r_div;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;

    logic       w_p_tick;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_hsync_next;
    logic       w_vsync_next;
    logic       w_video_on_next;

    assign w_p_tick = (r_div == DIV_LAST);

    // Scan counters advance once per pixel; y steps on the x wrap.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            if (r_x == X_LAST) begin
                w_x_next = 10'd0;
                if (r_y == Y_LAST) begin
                    w_y_next = 10'd0;
                end else begin
                    w_y_next = r_y + 10'd1;
                end
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Decoding the next-state counters keeps the registered sync outputs in step with x/y.
    always_comb begin
        w_hsync_next    = !((w_x_next >= X_HS_FIRST) && (w_x_next <= X_HS_LAST));
        w_vsync_next    = !((w_y_next >= Y_VS_FIRST) && (w_y_next <= Y_VS_LAST));
        w_video_on_next = (w_x_next <= X_VIS_LAST) && (w_y_next <= Y_VIS_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div      <= 2'd0;
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b1;
        end else begin
            r_div      <= w_p_tick ? 2'd0 : r_div + 2'd1;
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_hsync    <= w_hsync_next;
            r_vsync    <= w_vsync_next;
            r_video_on <= w_video_on_next;
        end
    end

    assign o_hsync      = r_hsync;
    assign o_vsync      = r_vsync;
    assign o_video_on   = r_video_on;
    assign o_p_tick     = w_p_tick;
    assign o_frame_tick = w_p_tick && (r_x == X_LAST) && (r_y == Y_LAST);
    assign o_x          = r_x;
    assign o_y          = r_y;

endmodule
